// File: rtl/riscv_i32_trace_unpack_if.sv
// Word-stream handshake feeding the trace unpacker.
// master: the stream source (e.g. a trace-buffer reader).
// slave : the unpacker consuming words.
interface riscv_i32_trace_unpack_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/riscv_i32_trace_unpack.sv
// Rebuilds the RISC-V trace bus from a packed 32-bit word stream.
// Each packet is one header word followed by payload words. The
// packet kind and header flags decide which payload words follow.
// Sequential packets take their PC from the next_pc tracker.
// Every record field and the valid pulse come from flops.
module riscv_i32_trace_unpack (
   input  logic                           clk,
   input  logic                           clk__enable,
   input  logic                           reset_n,
   riscv_i32_trace_unpack_if.slave        in_if,
   output logic                           trace__instr_valid,
   output logic [2:0]                     trace__mode,
   output logic [31:0]                    trace__instr_pc,
   output logic [31:0]                    trace__instruction,
   output logic                           trace__branch_taken,
   output logic [31:0]                    trace__branch_target,
   output logic                           trace__trap,
   output logic                           trace__ret,
   output logic                           trace__jalr,
   output logic                           trace__rfw_retire,
   output logic                           trace__rfw_data_valid,
   output logic [4:0]                     trace__rfw_rd,
   output logic [31:0]                    trace__rfw_data,
   output logic                           trace__bkpt_valid,
   output logic [3:0]                     trace__bkpt_reason,
   output logic                           decode_error,
   output logic [15:0]                    instr_count
);

   typedef enum logic [2:0] {
      S_HEADER = 3'd0,
      S_PC     = 3'd1,
      S_INSTR  = 3'd2,
      S_TARGET = 3'd3,
      S_DATA   = 3'd4
   } state_t;

   // Header flags are stored as in_data[27:9]; the reserved bits are not kept.
   localparam int H_BKPT_V = 0;
   localparam int H_DV     = 10;
   localparam int H_RETIRE = 11;
   localparam int H_BR     = 12;
   localparam int H_JALR   = 13;
   localparam int H_RET    = 14;
   localparam int H_TRAP   = 15;

   state_t       state_q, state_d;
   logic [18:0]  hdr_q, hdr_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  target_q, target_d;
   logic [31:0]  data_q, data_d;
   logic [31:0]  next_pc_q, next_pc_d;
   logic         pc_known_q, pc_known_d;
   logic         in_ready_q, in_ready_d;
   logic         err_q, err_d;
   logic [15:0]  count_q, count_d;

   logic         t_valid_q, t_valid_d;
   logic [2:0]   t_mode_q, t_mode_d;
   logic [31:0]  t_pc_q, t_pc_d;
   logic [31:0]  t_instr_q, t_instr_d;
   logic         t_br_q, t_br_d;
   logic [31:0]  t_target_q, t_target_d;
   logic         t_trap_q, t_trap_d;
   logic         t_ret_q, t_ret_d;
   logic         t_jalr_q, t_jalr_d;
   logic         t_retire_q, t_retire_d;
   logic         t_dv_q, t_dv_d;
   logic [4:0]   t_rd_q, t_rd_d;
   logic [31:0]  t_data_q, t_data_d;
   logic         t_bkpt_v_q, t_bkpt_v_d;
   logic [3:0]   t_bkpt_r_q, t_bkpt_r_d;

   logic         xfer_s;
   logic         emit_s;

   assign xfer_s = in_if.in_valid & in_ready_q & clk__enable;

   // Packet decoder: latches header and payload words and forms the next record.
   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      target_d   = target_q;
      data_d     = data_q;
      next_pc_d  = next_pc_q;
      pc_known_d = pc_known_q;
      err_d      = err_q;
      count_d    = count_q;
      in_ready_d = 1'b1;
      emit_s     = 1'b0;

      t_valid_d  = 1'b0;
      t_mode_d   = t_mode_q;
      t_pc_d     = t_pc_q;
      t_instr_d  = t_instr_q;
      t_br_d     = t_br_q;
      t_target_d = t_target_q;
      t_trap_d   = t_trap_q;
      t_ret_d    = t_ret_q;
      t_jalr_d   = t_jalr_q;
      t_retire_d = t_retire_q;
      t_dv_d     = t_dv_q;
      t_rd_d     = t_rd_q;
      t_data_d   = t_data_q;
      t_bkpt_v_d = t_bkpt_v_q;
      t_bkpt_r_d = t_bkpt_r_q;

      if (xfer_s) begin
         case (state_q)
            S_HEADER: begin
               case (in_if.in_data[31:28])
                  4'h0: begin
                     state_d = S_HEADER;
                  end
                  4'h1: begin
                     hdr_d    = in_if.in_data[27:9];
                     target_d = 32'd0;
                     data_d   = 32'd0;
                     state_d  = S_PC;
                  end
                  4'h2: begin
                     hdr_d    = in_if.in_data[27:9];
                     pc_d     = next_pc_q;
                     target_d = 32'd0;
                     data_d   = 32'd0;
                     state_d  = S_INSTR;
                     if (!pc_known_q) begin
                        err_d = 1'b1;
                     end else begin
                        err_d = err_q;
                     end
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_HEADER;
                  end
               endcase
            end
            S_PC: begin
               pc_d    = in_if.in_data;
               state_d = S_INSTR;
            end
            S_INSTR: begin
               instr_d = in_if.in_data;
               if (hdr_q[H_BR]) begin
                  state_d = S_TARGET;
               end else if (hdr_q[H_DV]) begin
                  state_d = S_DATA;
               end else begin
                  emit_s  = 1'b1;
                  state_d = S_HEADER;
               end
            end
            S_TARGET: begin
               target_d = in_if.in_data;
               if (hdr_q[H_DV]) begin
                  state_d = S_DATA;
               end else begin
                  emit_s  = 1'b1;
                  state_d = S_HEADER;
               end
            end
            S_DATA: begin
               data_d  = in_if.in_data;
               emit_s  = 1'b1;
               state_d = S_HEADER;
            end
            default: begin
               state_d = S_HEADER;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      if (emit_s) begin
         t_valid_d  = 1'b1;
         t_mode_d   = hdr_q[18:16];
         t_pc_d     = pc_d;
         t_instr_d  = instr_d;
         t_br_d     = hdr_q[H_BR];
         t_target_d = target_d;
         t_trap_d   = hdr_q[H_TRAP];
         t_ret_d    = hdr_q[H_RET];
         t_jalr_d   = hdr_q[H_JALR];
         t_retire_d = hdr_q[H_RETIRE];
         t_dv_d     = hdr_q[H_DV];
         t_rd_d     = hdr_q[9:5];
         t_data_d   = data_d;
         t_bkpt_v_d = hdr_q[H_BKPT_V];
         t_bkpt_r_d = hdr_q[4:1];
         next_pc_d  = hdr_q[H_BR] ? target_d : (pc_d + 32'd4);
         pc_known_d = 1'b1;
         count_d    = count_q + 16'd1;
      end else begin
         t_valid_d  = 1'b0;
      end
   end

   // State and record registers; everything holds while clk__enable is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_HEADER;
         hdr_q      <= 19'd0;
         pc_q       <= 32'd0;
         instr_q    <= 32'd0;
         target_q   <= 32'd0;
         data_q     <= 32'd0;
         next_pc_q  <= 32'd0;
         pc_known_q <= 1'b0;
         in_ready_q <= 1'b0;
         err_q      <= 1'b0;
         count_q    <= 16'd0;
         t_valid_q  <= 1'b0;
         t_mode_q   <= 3'd0;
         t_pc_q     <= 32'd0;
         t_instr_q  <= 32'd0;
         t_br_q     <= 1'b0;
         t_target_q <= 32'd0;
         t_trap_q   <= 1'b0;
         t_ret_q    <= 1'b0;
         t_jalr_q   <= 1'b0;
         t_retire_q <= 1'b0;
         t_dv_q     <= 1'b0;
         t_rd_q     <= 5'd0;
         t_data_q   <= 32'd0;
         t_bkpt_v_q <= 1'b0;
         t_bkpt_r_q <= 4'd0;
      end else if (clk__enable) begin
         state_q    <= state_d;
         hdr_q      <= hdr_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         target_q   <= target_d;
         data_q     <= data_d;
         next_pc_q  <= next_pc_d;
         pc_known_q <= pc_known_d;
         in_ready_q <= in_ready_d;
         err_q      <= err_d;
         count_q    <= count_d;
         t_valid_q  <= t_valid_d;
         t_mode_q   <= t_mode_d;
         t_pc_q     <= t_pc_d;
         t_instr_q  <= t_instr_d;
         t_br_q     <= t_br_d;
         t_target_q <= t_target_d;
         t_trap_q   <= t_trap_d;
         t_ret_q    <= t_ret_d;
         t_jalr_q   <= t_jalr_d;
         t_retire_q <= t_retire_d;
         t_dv_q     <= t_dv_d;
         t_rd_q     <= t_rd_d;
         t_data_q   <= t_data_d;
         t_bkpt_v_q <= t_bkpt_v_d;
         t_bkpt_r_q <= t_bkpt_r_d;
      end
   end

   assign in_if.in_ready        = in_ready_q;
   assign trace__instr_valid    = t_valid_q;
   assign trace__mode           = t_mode_q;
   assign trace__instr_pc       = t_pc_q;
   assign trace__instruction    = t_instr_q;
   assign trace__branch_taken   = t_br_q;
   assign trace__branch_target  = t_target_q;
   assign trace__trap           = t_trap_q;
   assign trace__ret            = t_ret_q;
   assign trace__jalr           = t_jalr_q;
   assign trace__rfw_retire     = t_retire_q;
   assign trace__rfw_data_valid = t_dv_q;
   assign trace__rfw_rd         = t_rd_q;
   assign trace__rfw_data       = t_data_q;
   assign trace__bkpt_valid     = t_bkpt_v_q;
   assign trace__bkpt_reason    = t_bkpt_r_q;
   assign decode_error          = err_q;
   assign instr_count           = count_q;

endmodule

// File: tb/tb_riscv_i32_trace_unpack.sv
// Directed bench for riscv_i32_trace_unpack with hand-computed expectations.
module tb_riscv_i32_trace_unpack;
   logic        clk;
   logic        clk__enable;
   logic        reset_n;
   logic        trace__instr_valid;
   logic [2:0]  trace__mode;
   logic [31:0] trace__instr_pc;
   logic [31:0] trace__instruction;
   logic        trace__branch_taken;
   logic [31:0] trace__branch_target;
   logic        trace__trap;
   logic        trace__ret;
   logic        trace__jalr;
   logic        trace__rfw_retire;
   logic        trace__rfw_data_valid;
   logic [4:0]  trace__rfw_rd;
   logic [31:0] trace__rfw_data;
   logic        trace__bkpt_valid;
   logic [3:0]  trace__bkpt_reason;
   logic        decode_error;
   logic [15:0] instr_count;

   int total = 0;
   int bad   = 0;

   riscv_i32_trace_unpack_if bus ();

   riscv_i32_trace_unpack dut (
      .clk                   (clk),
      .clk__enable           (clk__enable),
      .reset_n               (reset_n),
      .in_if                 (bus.slave),
      .trace__instr_valid    (trace__instr_valid),
      .trace__mode           (trace__mode),
      .trace__instr_pc       (trace__instr_pc),
      .trace__instruction    (trace__instruction),
      .trace__branch_taken   (trace__branch_taken),
      .trace__branch_target  (trace__branch_target),
      .trace__trap           (trace__trap),
      .trace__ret            (trace__ret),
      .trace__jalr           (trace__jalr),
      .trace__rfw_retire     (trace__rfw_retire),
      .trace__rfw_data_valid (trace__rfw_data_valid),
      .trace__rfw_rd         (trace__rfw_rd),
      .trace__rfw_data       (trace__rfw_data),
      .trace__bkpt_valid     (trace__bkpt_valid),
      .trace__bkpt_reason    (trace__bkpt_reason),
      .decode_error          (decode_error),
      .instr_count           (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one word and wait (bounded) for the enabled edge that accepts it.
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      while (!(clk__enable && bus.in_ready) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n < 20) begin
         @(posedge clk);
         #1;
      end else begin
         chk("send_timeout", 32'(n), 32'd0);
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      clk__enable  = 1'b1;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 32'd0;
      tick(3);

      // Reset state
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_valid", 32'(trace__instr_valid), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_err", 32'(decode_error), 32'd0);
      chk("rst_pc", trace__instr_pc, 32'd0);
      reset_n = 1'b1;
      tick(1);
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

      // Full packet, 3 words
      send(32'h1000_0000);
      send(32'h8000_0000);
      send(32'h0000_0013);
      chk("full_valid", 32'(trace__instr_valid), 32'd1);
      chk("full_pc", trace__instr_pc, 32'h8000_0000);
      chk("full_instr", trace__instruction, 32'h0000_0013);
      chk("full_count", 32'(instr_count), 32'd1);
      chk("full_err", 32'(decode_error), 32'd0);
      tick(1);
      chk("full_valid_drop", 32'(trace__instr_valid), 32'd0);

      // Sequential packet
      send(32'h2000_0000);
      send(32'h0010_0093);
      chk("seq_pc", trace__instr_pc, 32'h8000_0004);
      chk("seq_instr", trace__instruction, 32'h0010_0093);
      chk("seq_count", 32'(instr_count), 32'd2);
      chk("seq_err", 32'(decode_error), 32'd0);

      // Full packet: mode 3, branch taken, retire, data valid, rd 5
      send(32'h1639_4000);
      send(32'h0000_0100);
      send(32'h0000_0063);
      send(32'h0000_0200);
      send(32'hDEAD_BEEF);
      chk("br_valid", 32'(trace__instr_valid), 32'd1);
      chk("br_pc", trace__instr_pc, 32'h0000_0100);
      chk("br_target", trace__branch_target, 32'h0000_0200);
      chk("br_taken", 32'(trace__branch_taken), 32'd1);
      chk("br_rd", 32'(trace__rfw_rd), 32'd5);
      chk("br_data", trace__rfw_data, 32'hDEAD_BEEF);
      chk("br_mode", 32'(trace__mode), 32'd3);
      chk("br_retire", 32'(trace__rfw_retire), 32'd1);
      chk("br_dv", 32'(trace__rfw_data_valid), 32'd1);
      chk("br_count", 32'(instr_count), 32'd3);

      // Back-to-back sequential: trap, breakpoint reason 0xA, reserved bits set
      send(32'h2100_2BFF);
      send(32'h0000_0013);
      chk("b2b_pc", trace__instr_pc, 32'h0000_0200);
      chk("b2b_target_zero", trace__branch_target, 32'd0);
      chk("b2b_data_zero", trace__rfw_data, 32'd0);
      chk("b2b_rd", 32'(trace__rfw_rd), 32'd0);
      chk("b2b_trap", 32'(trace__trap), 32'd1);
      chk("b2b_bkpt_valid", 32'(trace__bkpt_valid), 32'd1);
      chk("b2b_bkpt_reason", 32'(trace__bkpt_reason), 32'hA);
      chk("b2b_mode", 32'(trace__mode), 32'd0);
      chk("b2b_count", 32'(instr_count), 32'd4);

      // Illegal kind: error, no record, next packet decodes
      send(32'h7000_0000);
      chk("bad_kind_err", 32'(decode_error), 32'd1);
      chk("bad_kind_valid", 32'(trace__instr_valid), 32'd0);
      chk("bad_kind_count", 32'(instr_count), 32'd4);
      send(32'h2000_0000);
      send(32'h1111_1111);
      chk("after_bad_pc", trace__instr_pc, 32'h0000_0204);
      chk("after_bad_instr", trace__instruction, 32'h1111_1111);
      chk("after_bad_count", 32'(instr_count), 32'd5);
      chk("err_sticky", 32'(decode_error), 32'd1);

      // Pads, in_valid gaps and clk__enable toggling mid-packet
      send(32'h0000_0000);
      send(32'h0000_0000);
      chk("pad_count", 32'(instr_count), 32'd5);
      chk("pad_valid", 32'(trace__instr_valid), 32'd0);
      send(32'h1000_0000);
      tick(2);
      clk__enable  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0300;
      tick(3);
      bus.in_valid = 1'b0;
      chk("en_low_count", 32'(instr_count), 32'd5);
      clk__enable = 1'b1;
      send(32'h0000_0300);
      tick(1);
      send(32'h2222_2222);
      chk("gap_valid", 32'(trace__instr_valid), 32'd1);
      chk("gap_pc", trace__instr_pc, 32'h0000_0300);
      chk("gap_instr", trace__instruction, 32'h2222_2222);
      chk("gap_count", 32'(instr_count), 32'd6);
      clk__enable = 1'b0;
      tick(3);
      chk("stretch_valid", 32'(trace__instr_valid), 32'd1);
      chk("stretch_count", 32'(instr_count), 32'd6);
      clk__enable = 1'b1;
      tick(1);
      chk("stretch_drop", 32'(trace__instr_valid), 32'd0);
      chk("stretch_count2", 32'(instr_count), 32'd6);

      // next_pc wrap
      send(32'h1000_0000);
      send(32'hFFFF_FFFC);
      send(32'h0000_0013);
      chk("wrap_src_pc", trace__instr_pc, 32'hFFFF_FFFC);
      send(32'h2000_0000);
      send(32'h0000_0013);
      chk("wrap_pc", trace__instr_pc, 32'h0000_0000);
      chk("wrap_count", 32'(instr_count), 32'd8);

      // Reset mid-packet after the PC word
      send(32'h1000_0000);
      send(32'h0000_0400);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(instr_count), 32'd0);
      chk("mid_rst_err", 32'(decode_error), 32'd0);
      chk("mid_rst_pc", trace__instr_pc, 32'd0);
      chk("mid_rst_instr", trace__instruction, 32'd0);
      chk("mid_rst_trap", 32'(trace__trap), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(1);
      send(32'h1000_0000);
      send(32'h0000_0500);
      send(32'h0000_0033);
      chk("post_rst_valid", 32'(trace__instr_valid), 32'd1);
      chk("post_rst_pc", trace__instr_pc, 32'h0000_0500);
      chk("post_rst_instr", trace__instruction, 32'h0000_0033);
      chk("post_rst_count", 32'(instr_count), 32'd1);
      chk("post_rst_err", 32'(decode_error), 32'd0);

      // Sequential packet first after reset
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      send(32'h2000_0000);
      send(32'h0000_0044);
      chk("seq_first_err", 32'(decode_error), 32'd1);
      chk("seq_first_valid", 32'(trace__instr_valid), 32'd1);
      chk("seq_first_pc", trace__instr_pc, 32'd0);
      chk("seq_first_instr", trace__instruction, 32'h0000_0044);
      chk("seq_first_count", 32'(instr_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
